// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider. Produces a registered divided
// waveform and period strobe, with ratio/mode changes applied only at period boundaries.
module clock_divider_prog #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RESET_DIV  = 4,
    parameter bit          RESET_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode_in,
    input  logic             div_load,
    output logic             clk_div,
    output logic             tick,
    output logic             div_ack,
    output logic             pend,
    output logic [WIDTH-1:0] div_cur
);

    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_DIV = (RESET_DIV < 2) ? MIN_DIV : WIDTH'(RESET_DIV);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic             r_mode;
    logic [WIDTH-1:0] r_pdiv;
    logic             r_pmode;
    logic             r_pend;
    logic             r_clk_div;
    logic             r_tick;
    logic             r_ack;

    logic [WIDTH-1:0] w_div_clamp;
    logic             w_wrap;
    logic [WIDTH-1:0] w_cnt_n;
    logic [WIDTH-1:0] w_div_n;
    logic             w_mode_n;
    logic [WIDTH-1:0] w_pdiv_n;
    logic             w_pmode_n;
    logic             w_pend_n;
    logic             w_clk_n;
    logic             w_tick_n;
    logic             w_ack_n;
    logic [WIDTH-1:0] w_half;

    assign w_div_clamp = (div_in < MIN_DIV) ? MIN_DIV : div_in;
    assign w_wrap      = en && (r_cnt == (r_div - WIDTH'(1)));

    // Next-state: a load on a wrap edge bypasses pending; outputs come from next-state counter.
    always_comb begin
        w_cnt_n   = r_cnt;
        w_div_n   = r_div;
        w_mode_n  = r_mode;
        w_pdiv_n  = r_pdiv;
        w_pmode_n = r_pmode;
        w_pend_n  = r_pend;
        w_clk_n   = r_clk_div;
        w_tick_n  = 1'b0;
        w_ack_n   = 1'b0;
        w_half    = '0;

        if (div_load) begin
            w_pdiv_n  = w_div_clamp;
            w_pmode_n = mode_in;
            w_pend_n  = 1'b1;
        end

        if (en) begin
            if (w_wrap) begin
                w_cnt_n  = '0;
                w_tick_n = 1'b1;
                if (div_load) begin
                    w_div_n  = w_div_clamp;
                    w_mode_n = mode_in;
                    w_pend_n = 1'b0;
                    w_ack_n  = 1'b1;
                end else if (r_pend) begin
                    w_div_n  = r_pdiv;
                    w_mode_n = r_pmode;
                    w_pend_n = 1'b0;
                    w_ack_n  = 1'b1;
                end
            end else begin
                w_cnt_n = r_cnt + WIDTH'(1);
            end
            w_half  = w_div_n - (w_div_n >> 1);
            w_clk_n = w_mode_n ? (w_cnt_n == '0) : (w_cnt_n < w_half);
        end
    end

    // State register; counter resets to N-1 so the first enabled edge is a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= RST_DIV - WIDTH'(1);
            r_div     <= RST_DIV;
            r_mode    <= RESET_MODE;
            r_pdiv    <= RST_DIV;
            r_pmode   <= RESET_MODE;
            r_pend    <= 1'b0;
            r_clk_div <= 1'b0;
            r_tick    <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_n;
            r_div     <= w_div_n;
            r_mode    <= w_mode_n;
            r_pdiv    <= w_pdiv_n;
            r_pmode   <= w_pmode_n;
            r_pend    <= w_pend_n;
            r_clk_div <= w_clk_n;
            r_tick    <= w_tick_n;
            r_ack     <= w_ack_n;
        end
    end

    assign clk_div = r_clk_div;
    assign tick    = r_tick;
    assign div_ack = r_ack;
    assign pend    = r_pend;
    assign div_cur = r_div;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: reset, ratio/mode loads, clamp, enable hold, async reset.
module tb_clock_divider_prog;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             mode_in;
    logic             div_load;
    logic             clk_div;
    logic             tick;
    logic             div_ack;
    logic             pend;
    logic [WIDTH-1:0] div_cur;

    int vectors = 0;
    int errs    = 0;

    clock_divider_prog #(.WIDTH(WIDTH), .RESET_DIV(4), .RESET_MODE(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .mode_in  (mode_in),
        .div_load (div_load),
        .clk_div  (clk_div),
        .tick     (tick),
        .div_ack  (div_ack),
        .pend     (pend),
        .div_cur  (div_cur)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_clk, input logic e_tick,
                           input logic e_ack, input logic e_pend, input int e_cur);
        chk({tag, ".clk_div"}, 32'(clk_div), 32'(e_clk));
        chk({tag, ".tick"},    32'(tick),    32'(e_tick));
        chk({tag, ".div_ack"}, 32'(div_ack), 32'(e_ack));
        chk({tag, ".pend"},    32'(pend),    32'(e_pend));
        chk({tag, ".div_cur"}, 32'(div_cur), 32'(e_cur));
    endtask

    // Runs `cycles` edges of a steady period of ratio n starting at phase `ph0`.
    task automatic run(input string tag, input int n, input bit m, input int ph0, input int cycles);
        int ph;
        int h;
        h = n - n / 2;
        for (int k = 0; k < cycles; k++) begin
            cyc();
            ph = (ph0 + k) % n;
            chk({tag, ".clk_div"}, 32'(clk_div), m ? 32'(ph == 0) : 32'(ph < h));
            chk({tag, ".tick"},    32'(tick),    32'(ph == 0));
            chk({tag, ".div_ack"}, 32'(div_ack), 32'd0);
            chk({tag, ".div_cur"}, 32'(div_cur), 32'(n));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; div_in = '0; mode_in = 1'b0; div_load = 1'b0;
        #1;
        chk_all("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 4);
        cyc(); cyc();
        chk_all("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 4);
        rst = 1'b0;

        // Default N=4: 1,1,0,0 with tick on cycles 1,5,9
        run("dflt4", 4, 1'b0, 0, 12);
        cyc(); chk_all("n4_c0", 1'b1, 1'b1, 1'b0, 1'b0, 4);
        cyc(); chk_all("n4_c1", 1'b1, 1'b0, 1'b0, 1'b0, 4);

        // Mid-period load of 6 at cnt=1
        div_in = 8'd6; div_load = 1'b1;
        cyc(); chk_all("mid_c2", 1'b0, 1'b0, 1'b0, 1'b1, 4);
        div_load = 1'b0;
        cyc(); chk_all("mid_c3", 1'b0, 1'b0, 1'b0, 1'b1, 4);
        cyc(); chk_all("mid_ack", 1'b1, 1'b1, 1'b1, 1'b0, 6);
        run("n6", 6, 1'b0, 1, 11);

        // Load 5 exactly on the wrap edge: bypass, pend never rises
        div_in = 8'd5; div_load = 1'b1;
        cyc(); chk_all("byp5_ack", 1'b1, 1'b1, 1'b1, 1'b0, 5);
        div_load = 1'b0;
        run("n5", 5, 1'b0, 1, 9);
        cyc(); chk_all("n5_c0", 1'b1, 1'b1, 1'b0, 1'b0, 5);

        // Overwrite 7 with 0 before the boundary; clamps to 2, single ack
        div_in = 8'd7; div_load = 1'b1;
        cyc(); chk_all("ovw_c1", 1'b1, 1'b0, 1'b0, 1'b1, 5);
        div_in = 8'd0;
        cyc(); chk_all("ovw_c2", 1'b1, 1'b0, 1'b0, 1'b1, 5);
        div_load = 1'b0;
        cyc(); chk_all("ovw_c3", 1'b0, 1'b0, 1'b0, 1'b1, 5);
        cyc(); chk_all("ovw_c4", 1'b0, 1'b0, 1'b0, 1'b1, 5);
        cyc(); chk_all("ovw_ack", 1'b1, 1'b1, 1'b1, 1'b0, 2);
        run("n2", 2, 1'b0, 1, 7);

        // Pulse mode N=3
        div_in = 8'd3; mode_in = 1'b1; div_load = 1'b1;
        cyc(); chk_all("pls_ack", 1'b1, 1'b1, 1'b1, 1'b0, 3);
        div_load = 1'b0; mode_in = 1'b0;
        run("pls3", 3, 1'b1, 1, 8);

        // Back to 50% N=6, then hold en low mid-period while loading 4
        div_in = 8'd6; div_load = 1'b1;
        cyc(); chk_all("e6_ack", 1'b1, 1'b1, 1'b1, 1'b0, 6);
        div_load = 1'b0;
        cyc(); chk_all("e6_c1", 1'b1, 1'b0, 1'b0, 1'b0, 6);
        en = 1'b0; div_in = 8'd4; div_load = 1'b1;
        cyc(); chk_all("enlo_load", 1'b1, 1'b0, 1'b0, 1'b1, 6);
        div_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(); chk_all("enlo_hold", 1'b1, 1'b0, 1'b0, 1'b1, 6);
        end
        en = 1'b1;
        cyc(); chk_all("enhi_c2", 1'b1, 1'b0, 1'b0, 1'b1, 6);
        cyc(); chk_all("enhi_c3", 1'b0, 1'b0, 1'b0, 1'b1, 6);
        cyc(); chk_all("enhi_c4", 1'b0, 1'b0, 1'b0, 1'b1, 6);
        cyc(); chk_all("enhi_c5", 1'b0, 1'b0, 1'b0, 1'b1, 6);
        cyc(); chk_all("enhi_ack", 1'b1, 1'b1, 1'b1, 1'b0, 4);

        // Reset while a request is pending
        div_in = 8'd7; div_load = 1'b1;
        cyc(); chk_all("rp_c1", 1'b1, 1'b0, 1'b0, 1'b1, 4);
        div_load = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all("rp_async", 1'b0, 1'b0, 1'b0, 1'b0, 4);
        cyc();
        rst = 1'b0;
        run("rp_after", 4, 1'b0, 0, 9);
        chk("rp_nopend", 32'(pend), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/clock_divider_prog.md
# clock_divider_prog

Runtime-programmable integer clock divider, the parametrised successor to the fixed divide-by-8 divider. It produces a registered divided clock-enable waveform (`clk_div`) and a one-cycle period strobe (`tick`) for downstream logic in the `clk` domain. The divide ratio and duty mode can be changed at run time through a load handshake. Changes take effect only at a period boundary, so the output never shows a truncated or runt period.

## Interface
- `WIDTH`, 8: width of the divide-ratio field; maximum ratio is 2^WIDTH-1.
- `RESET_DIV`, 4: divide ratio active out of reset; values below 2 are clamped to 2.
- `RESET_MODE`, 0: duty mode active out of reset; 0 = 50% duty, 1 = pulse.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `en`  in  1  count enable; when low, all state freezes.
- `div_in`  in  WIDTH  requested divide ratio N.
- `mode_in`  in  1  requested duty mode.
- `div_load`  in  1  one-cycle request that captures `div_in` and `mode_in`.
- `clk_div`  out  1  divided output, registered.
- `tick`  out  1  one-cycle strobe at the start of each period, registered.
- `div_ack`  out  1  one-cycle pulse when a requested ratio becomes active.
- `pend`  out  1  a loaded request is waiting for the next boundary.
- `div_cur`  out  WIDTH  currently active ratio, after clamping.

## Operation
- Internal state:
  - counter `cnt[WIDTH-1:0]`
  - active ratio N and active mode
  - pending ratio, pending mode and the `pend` flag
- Clamp rule: any requested ratio below 2 becomes 2. Clamping is applied at capture time, so `div_cur` never reads 0 or 1.
- Period length is N enabled cycles. `cnt` runs 0..N-1; the wrap edge is the edge where `cnt == N-1` and `en == 1`.
- 50% mode: `clk_div` is high while `cnt < H` and low otherwise, with H = N - (N>>1).
  - Even N gives exact 50% duty.
  - Odd N gives one extra high cycle. Example: N=5 gives 3 high, 2 low.
- Pulse mode: `clk_div` is high only when `cnt == 0`, so it is identical to `tick`.
- `tick` is high in the cycle where `cnt == 0`, i.e. the cycle after each wrap edge.
- Outputs are computed from the next-state counter and registered, so `clk_div` and `tick` are glitch-free flops.
- Load handshake:
  - `div_load` high captures the clamped `div_in` and `mode_in` into the pending registers and sets `pend`.
  - A second load before the boundary overwrites the pending values; the last request wins, and only one `div_ack` is issued.
  - On a wrap edge with `pend` set: the pending values become active, `cnt` goes to 0, `pend` clears, and `div_ack` pulses for one cycle.
  - `div_load` coinciding with a wrap edge bypasses the pending registers. The new values are active from `cnt == 0` of the new period and `div_ack` pulses; `pend` stays 0.
  - The mode and ratio of the period in progress are never altered mid-period.
- `en` low: `cnt`, `clk_div`, the active and pending registers all hold, and `tick` is 0.
  - Loads are still captured into pending while `en` is low.
  - Wrap edges and acks require `en` high.

## Timing
- Reset values (asynchronous):
  - `clk_div` = 0, `tick` = 0, `div_ack` = 0, `pend` = 0
  - `div_cur` = clamp(`RESET_DIV`), active mode = `RESET_MODE`
  - `cnt` = N-1, so the first enabled edge is a wrap
- First enabled edge after reset release: `cnt` goes to 0, and `clk_div` and `tick` both go to 1. Latency from reset release to output is one enabled cycle.
- `div_ack`, the `div_cur` update and the first `tick` of the new period all appear in the same cycle, one edge after the wrap edge.
- `pend` rises one cycle after the `div_load` edge. It falls in the same cycle `div_ack` rises.
- Reset asserted mid-period: all state returns to reset values immediately, without waiting for a clock. Any pending request is discarded and no ack is issued.
- Counter arithmetic is WIDTH bits. The maximum ratio 2^WIDTH-1 gives `cnt` 0..2^WIDTH-2, so the counter never overflows.

## Test plan
- Reset defaults (N=4, 50% mode), `en`=1, release reset: `clk_div` = 1,1,0,0 repeating; `tick` high on cycles 1, 5, 9; `div_cur` = 4.
- Odd ratio: load 5 in 50% mode. After `div_ack`, `clk_div` = 1,1,1,0,0 repeating and `tick` has a period of 5.
- Mid-period load: N=4, load 6 when `cnt`=1. The current period completes with 2 high, 2 low. `pend` = 1 until the wrap, `div_ack` coincides with the next `tick`, then periods are 3 high, 3 low.
- Overwrite and clamp: load 7, then load 0 before the boundary. Exactly one `div_ack` is issued; `div_cur` = 2 and `clk_div` toggles every cycle.
- Pulse mode: load N=3 with `mode_in`=1. `clk_div` equals `tick` = 1,0,0 repeating.
- `en` held low for 5 cycles mid-period: `clk_div` holds its level, `tick` stays 0, and the period resumes with the same remaining count.
- Reset asserted while `pend`=1: outputs clear asynchronously and the pending request is discarded. After release, `div_cur` = 4 and no `div_ack` appears.
